// File: rtl/alu_pkg.sv
// Shared opcode and flag-index constants for the ALU result stage and its flag generator.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_CMP = 3'd5;

    localparam int unsigned FLG_Z  = 0;
    localparam int unsigned FLG_C  = 1;
    localparam int unsigned FLG_N  = 2;
    localparam int unsigned FLG_EQ = 3;
    localparam int unsigned FLG_LT = 4;
    localparam int unsigned FLG_GT = 5;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag derivation for one {result, cout, op} tuple.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] result,
    input  logic             cout,
    input  logic [2:0]       op,
    output logic [5:0]       flags
);

    always_comb begin
        flags = '0;
        if (op == OP_CMP) begin
            // Comparator packs gt/lt/eq into the low three result bits.
            flags[FLG_GT] = result[2];
            flags[FLG_LT] = result[1];
            flags[FLG_EQ] = result[0];
        end else begin
            flags[FLG_Z] = (result == '0);
            flags[FLG_C] = cout;
            flags[FLG_N] = result[WIDTH-1];
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered FIFO output stage for ALU results with per-entry status flags.
// Optional push statistics counters enabled by ALU_RESULT_STAGE_STATS_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_cout,
    input  logic [2:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [2:0]               out_op,
    output logic [5:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count
`ifdef ALU_RESULT_STAGE_STATS_EN
    ,
    output logic [7:0]               cmp_cnt,
    output logic [7:0]               carry_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] res_mem_q [DEPTH];
    logic [WIDTH-1:0] res_mem_d [DEPTH];
    logic [2:0]       op_mem_q  [DEPTH];
    logic [2:0]       op_mem_d  [DEPTH];
    logic [5:0]       flg_mem_q [DEPTH];
    logic [5:0]       flg_mem_d [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic       full, empty, push, pop;
    logic [5:0] push_flags;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = in_valid && !full;
    assign pop   = !empty && out_ready;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result (in_result),
        .cout   (in_cout),
        .op     (in_op),
        .flags  (push_flags)
    );

    always_comb begin
        res_mem_d = res_mem_q;
        op_mem_d  = op_mem_q;
        flg_mem_d = flg_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            res_mem_d[wr_ptr_q] = in_result;
            op_mem_d[wr_ptr_q]  = in_op;
            flg_mem_d[wr_ptr_q] = push_flags;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_mem_q <= '{default: '0};
            op_mem_q  <= '{default: '0};
            flg_mem_q <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            res_mem_q <= res_mem_d;
            op_mem_q  <= op_mem_d;
            flg_mem_q <= flg_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Head is shown straight from storage; zeroed while empty.
    always_comb begin
        in_ready   = !full;
        out_valid  = !empty;
        count      = count_q;
        out_result = '0;
        out_op     = '0;
        out_flags  = '0;
        if (!empty) begin
            out_result = res_mem_q[rd_ptr_q];
            out_op     = op_mem_q[rd_ptr_q];
            out_flags  = flg_mem_q[rd_ptr_q];
        end
    end

`ifdef ALU_RESULT_STAGE_STATS_EN
    logic [7:0] cmp_cnt_q, cmp_cnt_d;
    logic [7:0] carry_cnt_q, carry_cnt_d;

    always_comb begin
        cmp_cnt_d   = cmp_cnt_q;
        carry_cnt_d = carry_cnt_q;
        if (push && (in_op == OP_CMP) && (cmp_cnt_q != '1)) begin
            cmp_cnt_d = cmp_cnt_q + 8'd1;
        end
        if (push && push_flags[FLG_C] && (carry_cnt_q != '1)) begin
            carry_cnt_d = carry_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_cnt_q   <= '0;
            carry_cnt_q <= '0;
        end else begin
            cmp_cnt_q   <= cmp_cnt_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign cmp_cnt   = cmp_cnt_q;
    assign carry_cnt = carry_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: queue-based reference model plus directed literal checks.
module tb_alu_result_stage;

    localparam int W = 4;
    localparam int D = 2;
    localparam logic [2:0] T_ADD = 3'd0;
    localparam logic [2:0] T_SUB = 3'd1;
    localparam logic [2:0] T_CMP = 3'd5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_result = '0;
    logic         in_cout = 1'b0;
    logic [2:0]   in_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic [2:0]   out_op;
    logic [5:0]   out_flags;
    logic [1:0]   count;
`ifdef ALU_RESULT_STAGE_STATS_EN
    logic [7:0]   cmp_cnt;
    logic [7:0]   carry_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_cout    (in_cout),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_flags  (out_flags),
        .count      (count)
`ifdef ALU_RESULT_STAGE_STATS_EN
        ,
        .cmp_cnt    (cmp_cnt),
        .carry_cnt  (carry_cnt)
`endif
    );

    typedef struct {
        logic [W-1:0] res;
        logic [2:0]   op;
        logic [5:0]   fl;
    } ent_t;

    ent_t mq[$];
    int   m_cmp = 0;
    int   m_carry = 0;

    // Flags as the rules state them: {gt,lt,eq,n,c,z}.
    function automatic logic [5:0] exp_flags(logic [W-1:0] r, logic c, logic [2:0] op);
        if (op == T_CMP) return {r[2], r[1], r[0], 3'b000};
        return {3'b000, r[W-1], c, (r == 0)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy decided from the model's own queue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cmp = 0;
            m_carry = 0;
        end else begin
            bit do_push, do_pop;
            ent_t e;
            do_push = in_valid && (mq.size() < D);
            do_pop  = (mq.size() > 0) && out_ready;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.res = in_result;
                e.op  = in_op;
                e.fl  = exp_flags(in_result, in_cout, in_op);
                mq.push_back(e);
                if (in_op == T_CMP && m_cmp < 255) m_cmp++;
                if (e.fl[1] && m_carry < 255) m_carry++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_count", 32'(count), 32'(mq.size()));
            check("cyc_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            check("cyc_in_ready", 32'(in_ready), 32'(mq.size() < D));
            if (mq.size() > 0) begin
                check("cyc_out_result", 32'(out_result), 32'(mq[0].res));
                check("cyc_out_op", 32'(out_op), 32'(mq[0].op));
                check("cyc_out_flags", 32'(out_flags), 32'(mq[0].fl));
            end else begin
                check("cyc_empty_outs", {out_result, out_op, out_flags}, 32'd0);
            end
`ifdef ALU_RESULT_STAGE_STATS_EN
            check("cyc_cmp_cnt", 32'(cmp_cnt), 32'(m_cmp));
            check("cyc_carry_cnt", 32'(carry_cnt), 32'(m_carry));
`endif
        end
    end

    // Called at a negedge: drive, let one rising edge pass, return at the next negedge.
    task automatic step(bit v, logic [W-1:0] r, logic c, logic [2:0] op, bit ordy);
        in_valid  = v;
        in_result = r;
        in_cout   = c;
        in_op     = op;
        out_ready = ordy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        bit v, hold, ordy, acc;
        logic [W-1:0] r;
        logic c;
        logic [2:0] o;

        @(negedge clk);
        do_reset();

        step(1, 4'h0, 1'b1, T_ADD, 0);
        check("add_zero_flags", 32'(out_flags), 32'b000011);
        check("add_zero_count", 32'(count), 32'd1);
        step(1, 4'b0100, 1'b0, T_CMP, 0);
        check("full_count", 32'(count), 32'd2);
        check("full_in_ready", 32'(in_ready), 32'd0);
        step(1, 4'hF, 1'b1, T_ADD, 1);
        check("full_pop_count", 32'(count), 32'd1);
        check("cmp_head_result", 32'(out_result), 32'b0100);
        check("cmp_head_flags", 32'(out_flags), 32'b100000);
        step(0, 4'h0, 1'b0, T_ADD, 1);
        check("dropped_push_count", 32'(count), 32'd0);
        check("dropped_push_valid", 32'(out_valid), 32'd0);

        step(1, 4'd1, 1'b0, T_ADD, 0);
        for (int k = 2; k <= 11; k++) begin
            step(1, 4'(k), 1'b0, T_ADD, 1);
            check("stream_count", 32'(count), 32'd1);
            check("stream_result", 32'(out_result), 32'(k));
        end
        step(0, 4'h0, 1'b0, T_ADD, 1);

        step(1, 4'b1000, 1'b0, T_SUB, 0);
        check("sub_neg_flags", 32'(out_flags), 32'b000100);
        step(0, 4'h0, 1'b0, T_ADD, 1);

        step(1, 4'h3, 1'b0, T_ADD, 0);
        step(1, 4'h5, 1'b1, T_ADD, 0);
        check("midrst_pre_count", 32'(count), 32'd2);
        do_reset();

        hold = 0;
        v = 0; r = '0; c = 0; o = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                o = 3'($urandom_range(0, 7));
                if (o == T_CMP) begin
                    r = 4'(1 << $urandom_range(0, 2));
                    c = 1'b0;
                end else begin
                    r = 4'($urandom);
                    c = 1'($urandom);
                end
            end
            ordy = ($urandom_range(0, 2) != 0);
            acc  = v && (mq.size() < D);
            hold = v && !acc;
            step(v, r, c, o, ordy);
        end
        step(0, 4'h0, 1'b0, T_ADD, 1);
        step(0, 4'h0, 1'b0, T_ADD, 1);

`ifdef ALU_RESULT_STAGE_STATS_EN
        do_reset();
        for (int i = 0; i < 300; i++) step(1, 4'b0001, 1'b0, T_CMP, 1);
        check("stats_cmp_sat", 32'(cmp_cnt), 32'd255);
        check("stats_carry_zero", 32'(carry_cnt), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 4'h9, 1'b1, T_ADD, 1);
        check("stats_carry_three", 32'(carry_cnt), 32'd3);
        step(0, 4'h0, 1'b0, T_ADD, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
